// File: rtl/bcd_scan_display_pkg.sv
// Shared types and constants for the BCD scan display.
// Holds the conversion FSM state enum, the BCD register width, and the
// active-high 7-segment glyphs. Glyph bit order is {g,f,e,d,c,b,a}.
package bcd_scan_display_pkg;

  localparam int unsigned BCD_W = 12;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_N = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h40;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Active-high glyph for one BCD digit; non-decimal codes render blank.
  function automatic logic [SEG_W-1:0] digit_glyph(input logic [3:0] d);
    logic [SEG_W-1:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_scan_display_bin2bcd_serial.sv
// Serial double-dabble converter: 8-bit binary to 12-bit BCD, one bit/cycle.
// Ports: clk, rst (sync, active-low), start (load bin, clear BCD),
//        bin[7:0], done (one-cycle pulse after the 8th shift), bcd[11:0].
module bin2bcd_serial
  import bcd_scan_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [7:0]       sr;
  logic [2:0]       cnt;
  logic             active;
  logic [BCD_W-1:0] adj_c;
  logic [BCD_W+7:0] sh_c;

  // Add 3 to every nibble >= 5, then shift BCD and binary together.
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    sh_c = {adj_c, sr} << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr     <= '0;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr     <= bin;
        bcd    <= '0;
        cnt    <= '0;
        active <= 1'b1;
      end else if (active) begin
        bcd <= sh_c[BCD_W+7:8];
        sr  <= sh_c[7:0];
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Signed result to 5-digit multiplexed 7-segment display.
// Ports: clk, rst (sync, active-low), result_valid (strobe), result[7:0]
//        (two's complement), ovf; busy (conversion running), seg_out[6:0]
//        ({g..a}, polarity per SEG_ACTIVE_LOW), seg_sel[4:0] (one-hot, bit0 = ones).
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_valid,
  input  logic [7:0]       result,
  input  logic             ovf,
  output logic             busy,
  output logic [SEG_W-1:0] seg_out,
  output logic [DIG_N-1:0] seg_sel
);

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic             accept_c, load_c, store_c;

  logic [7:0]       hold_res;
  logic             hold_ovf;
  logic             sign_l, ovf_l;
  logic [7:0]       mag_c;
  logic             bcd_done;
  logic [BCD_W-1:0] bcd;

  logic [3:0]       dig_ones, dig_tens, dig_hund;
  logic             disp_sign, disp_ovf;

  logic [15:0]      scan_cnt;
  logic             wrap_c;
  logic [DIG_N-1:0] sel_nxt;
  logic [SEG_W-1:0] glyph_c;

  // Conversion FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Conversion FSM: next state and control strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    load_c    = 1'b0;
    store_c   = 1'b0;
    case (state)
      IDLE: begin
        if (result_valid) begin
          accept_c  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_c    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == 3'd7) state_nxt = STORE;
        else             cnt_nxt   = cnt + 3'd1;
      end
      STORE: begin
        store_c   = bcd_done;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // |result| as unsigned; -128 maps to 128 since 8'h80 negates to itself.
  assign mag_c = hold_res[7] ? 8'(8'd0 - hold_res) : hold_res;

  bin2bcd_serial u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (load_c),
    .bin   (mag_c),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Capture the strobe payload, latch sign/ovf in LOAD, commit digits in STORE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_res  <= '0;
      hold_ovf  <= 1'b0;
      sign_l    <= 1'b0;
      ovf_l     <= 1'b0;
      dig_ones  <= '0;
      dig_tens  <= '0;
      dig_hund  <= '0;
      disp_sign <= 1'b0;
      disp_ovf  <= 1'b0;
    end else begin
      if (accept_c) begin
        hold_res <= result;
        hold_ovf <= ovf;
      end
      if (load_c) begin
        sign_l <= hold_res[7];
        ovf_l  <= hold_ovf;
      end
      if (store_c) begin
        dig_ones  <= bcd[3:0];
        dig_tens  <= bcd[7:4];
        dig_hund  <= bcd[11:8];
        disp_sign <= sign_l;
        disp_ovf  <= ovf_l;
      end
    end
  end

  assign wrap_c  = (scan_cnt == SCAN_DIV - 16'd1);
  assign sel_nxt = wrap_c ? {seg_sel[DIG_N-2:0], seg_sel[DIG_N-1]} : seg_sel;

  // Glyph for the digit that will be selected after this edge.
  always_comb begin
    glyph_c = SEG_BLANK;
    case (sel_nxt)
      5'b00001: glyph_c = disp_ovf ? SEG_BLANK : digit_glyph(dig_ones);
      5'b00010: glyph_c = (disp_ovf || (dig_hund == 4'd0 && dig_tens == 4'd0))
                          ? SEG_BLANK : digit_glyph(dig_tens);
      5'b00100: glyph_c = (disp_ovf || dig_hund == 4'd0)
                          ? SEG_BLANK : digit_glyph(dig_hund);
      5'b01000: glyph_c = (!disp_ovf && disp_sign) ? SEG_MINUS : SEG_BLANK;
      5'b10000: glyph_c = disp_ovf ? SEG_E : SEG_BLANK;
      default:  glyph_c = SEG_BLANK;
    endcase
  end

  // Scan counter; select and segments share an edge so digits never ghost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt <= '0;
      seg_sel  <= 5'b00001;
      seg_out  <= SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
    end else begin
      scan_cnt <= wrap_c ? 16'd0 : scan_cnt + 16'd1;
      seg_sel  <= sel_nxt;
      seg_out  <= SEG_ACTIVE_LOW ? ~glyph_c : glyph_c;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized self-checking bench for bcd_scan_display against a decimal
// arithmetic model of the expected five-digit display.
module tb_bcd_scan_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       result_valid = 1'b0;
  logic [7:0] result = 8'd0;
  logic       ovf = 1'b0;
  logic       busy;
  logic [6:0] seg_out;
  logic [4:0] seg_sel;

  int n_cmp = 0;
  int n_err = 0;
  int ecount = 0;

  logic [7:0] m_res = 8'd0;
  logic       m_ovf = 1'b0;

  logic [6:0] dtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_scan_display #(
    .SCAN_DIV       (16'(SCAN_DIV)),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_valid (result_valid),
    .result       (result),
    .ovf          (ovf),
    .busy         (busy),
    .seg_out      (seg_out),
    .seg_sel      (seg_sel)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scanned digit is a plain function of it.
  always @(posedge clk) ecount <= rst ? ecount + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected active-low pattern for digit position idx of the modelled value.
  function automatic logic [6:0] exp_seg(input int idx);
    int mag, h, t, o;
    logic [6:0] g;
    mag = m_res[7] ? 256 - int'(m_res) : int'(m_res);
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    g = 7'h00;
    case (idx)
      0: g = m_ovf ? 7'h00 : dtab[o];
      1: g = (m_ovf || (h == 0 && t == 0)) ? 7'h00 : dtab[t];
      2: g = (m_ovf || h == 0) ? 7'h00 : dtab[h];
      3: g = (!m_ovf && m_res[7]) ? 7'h40 : 7'h00;
      4: g = m_ovf ? 7'h79 : 7'h00;
      default: g = 7'h00;
    endcase
    return ~g;
  endfunction

  task automatic check_display(input int cycles);
    int idx;
    for (int k = 0; k < cycles; k++) begin
      idx = (ecount / SCAN_DIV) % 5;
      check("seg_sel", 32'(seg_sel), 32'(5'b00001 << idx));
      check("seg_out", 32'(seg_out), 32'(exp_seg(idx)));
      @(negedge clk);
    end
  endtask

  // Called at a negedge; strobe is sampled on the next rising edge.
  task automatic send(input logic [7:0] r, input logic o);
    result = r;
    ovf = o;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    result = 8'($urandom_range(0, 255));
    ovf = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic convert(input logic [7:0] r, input logic o);
    int c;
    send(r, o);
    wait_idle(c);
    check("busy_cycles", 32'(c), 32'd10);
    m_res = r;
    m_ovf = o;
    repeat (2) @(negedge clk);
    check_display(5 * SCAN_DIV);
  endtask

  // First strobe accepted, second lands gap+1 cycles later and is dropped.
  task automatic convert_with_ignored(input logic [7:0] r1, input logic [7:0] r2, input int gap);
    int c;
    send(r1, 1'b0);
    repeat (gap) @(negedge clk);
    send(r2, 1'b0);
    wait_idle(c);
    check("busy_ignore", 32'(c), 32'(9 - gap));
    m_res = r1;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_display(5 * SCAN_DIV);
  endtask

  initial begin
    int c;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sel", 32'(seg_sel), 32'd1);
    check("rst_seg", 32'(seg_out), 32'h40);
    rst = 1'b1;
    check_display(6 * SCAN_DIV);

    convert(8'd123, 1'b0);
    convert(8'h80, 1'b0);
    convert(8'hF9, 1'b0);
    convert(8'd5, 1'b1);
    convert(8'd0, 1'b0);
    convert(8'd127, 1'b0);
    convert_with_ignored(8'd42, 8'd9, 2);

    send(8'd99, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(seg_sel), 32'd1);
    check("abort_seg", 32'(seg_out), 32'h40);
    rst = 1'b1;
    m_res = 8'd0;
    m_ovf = 1'b0;
    check_display(5 * SCAN_DIV);
    convert(8'd7, 1'b0);

    repeat (12) convert(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    repeat (4) convert_with_ignored(8'($urandom_range(0, 255)),
                                    8'($urandom_range(0, 255)),
                                    $urandom_range(0, 8));

    wait_idle(c);
    check("final_idle", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter SCAN_DIV, default 16'd50000, clock cycles each digit stays selected (legal range 2..65535).
REQ-002 Parameter SEG_ACTIVE_LOW, default 1, 1 = segment outputs active-low (common-anode board).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 result_valid  input  1  one-cycle strobe from the calculator `done` path: result and ovf are valid this cycle.
REQ-006 result  input  8  calculator result, two's complement (-128..127).
REQ-007 ovf  input  1  arithmetic overflow/error flag, sampled with result_valid.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 seg_out  output  7  segments {g,f,e,d,c,b,a} of the selected digit.
REQ-010 seg_sel  output  5  one-hot digit select, active-high; bit 0 = rightmost digit.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, SHIFT and STORE.
- IDLE->LOAD on result_valid.
- LOAD->SHIFT after 1 cycle.
- SHIFT->STORE after exactly 8 cycles.
- STORE->IDLE after 1 cycle.
REQ-012 result_valid SHALL be accepted only in IDLE. Strobes while busy=1 SHALL be ignored, with no queuing.
REQ-013 In LOAD the block SHALL latch:
- sign = result[7];
- magnitude = |result| as 8-bit unsigned, so -128 yields 128 with no truncation;
- ovf into an internal flag.
REQ-014 In SHIFT the block SHALL run double-dabble, one magnitude bit per cycle, MSB first, on a 12-bit BCD register. Before each shift, add 3 to any nibble >= 5.
REQ-015 busy SHALL be high in LOAD, SHIFT and STORE, and low in IDLE.
REQ-016 Latency: a strobe accepted at edge N SHALL update the displayed digit registers at edge N+10, and busy SHALL fall at the same edge.
REQ-017 Digit map:
- sel0 = ones;
- sel1 = tens;
- sel2 = hundreds;
- sel3 = '-' (segment g only) if sign=1, else blank;
- sel4 = 'E' if ovf=1, else blank.
REQ-018 Leading-zero blanking:
- hundreds blank when 0;
- tens blank when hundreds and tens are both 0;
- ones always shown.
REQ-019 When ovf=1, digits sel0..sel3 SHALL be blank, regardless of result.
REQ-020 A scan counter SHALL count 0..SCAN_DIV-1 and wrap. On wrap, seg_sel rotates left one position, and 10000 wraps to 00001.
REQ-021 seg_out SHALL be registered and SHALL change on the same edge as seg_sel, so there is no cross-digit ghosting.
REQ-022 Scanning SHALL continue unaffected during conversion; the old value is shown until STORE.
REQ-023 Segment polarity SHALL follow SEG_ACTIVE_LOW. With the default, blank = 7'b1111111 and '0' = 7'b1000000.

Reset
REQ-024 With rst=0 at an edge, the block SHALL return:
- state = IDLE;
- busy = 0;
- scan counter = 0;
- seg_sel = 5'b00001;
- stored digits = 0, sign = 0, ovf = 0.
REQ-025 After reset, seg_out SHALL show '0' on sel0 and blank on all other digits.
REQ-026 Reset during LOAD, SHIFT or STORE SHALL abort the conversion with no partial digit update. Reset has priority over result_valid in the same cycle.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enum;
- 7-segment glyph constants (digits 0-9, MINUS, E, BLANK);
- the BCD width constant (12).
REQ-028 The shift/add-3 engine SHALL be one sub-module, bin2bcd_serial (start, 8-bit in, done, 12-bit BCD out), instantiated once. The scan multiplexer stays in bcd_scan_display.

Verification
REQ-029 Reset, then idle for 5*SCAN_DIV cycles -> seg_sel walks 00001,00010,00100,01000,10000,00001. seg_out = '0' only when seg_sel=00001, otherwise blank.
REQ-030 result_valid with result=8'd123, ovf=0 -> busy high for exactly 10 cycles. Display shows blank,blank,1,2,3 (sel4..sel0).
REQ-031 result=8'h80 (-128) -> display shows blank,'-',1,2,8. result=8'hF9 (-7) -> blank,'-',blank,blank,7.
REQ-032 result=8'd5 with ovf=1 -> sel4='E', sel3..sel0 blank.
REQ-033 Second strobe (result=8'd9) three cycles after a first strobe (result=8'd42) -> second ignored, display shows 42.
REQ-034 rst=0 asserted during SHIFT after loading 8'd99 -> busy=0 next cycle, display returns to the reset value; a strobe with 8'd7 afterwards -> shows 7 after 10 cycles.
